// File: rtl/stop_it_rounds.sv
// stop_it_rounds: Stop-It reaction-game controller with tick-enabled timing,
// selectable count direction, LED progress register and a lives limit.
module stop_it_rounds #(
    parameter int                 NUM_LEDS    = 16,
    parameter int                 COUNT_W     = 5,
    parameter int                 START_TICKS = 8,
    parameter int                 SHOW_TICKS  = 16,
    parameter int                 MAX_MISSES  = 3,
    parameter logic [COUNT_W-1:0] LFSR_TAPS   = 5'h14,
    parameter logic [COUNT_W-1:0] LFSR_SEED   = 5'h01
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                go_i,
    input  logic                stop_i,
    input  logic                load_i,
    input  logic                mode_i,
    input  logic [NUM_LEDS-1:0] switches_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic [COUNT_W-1:0]  count_o,
    output logic [COUNT_W-1:0]  target_o,
    output logic                count_en_o,
    output logic                target_en_o,
    output logic [3:0]          misses_o,
    output logic [2:0]          state_o,
    output logic                won_o,
    output logic                lost_o
);

    localparam int MAXT = (START_TICKS > SHOW_TICKS) ? START_TICKS : SHOW_TICKS;
    localparam int TW   = (MAXT < 2) ? 1 : $clog2(MAXT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STARTING = 3'd1,
        S_COUNTING = 3'd2,
        S_CORRECT  = 3'd3,
        S_WRONG    = 3'd4,
        S_WON      = 3'd5,
        S_LOST     = 3'd6
    } state_t;

    state_t              r_state, w_next;
    logic [COUNT_W-1:0]  r_count, r_target, r_lfsr, w_lfsr_next;
    logic [TW-1:0]       r_timer;
    logic [NUM_LEDS-1:0] r_leds, w_leds_shl, w_leds_shr;
    logic [3:0]          r_misses, w_misses_inc;
    logic                r_mode;
    logic                w_start_done, w_show_done;

    // Phase ends only on a tick so durations are counted in ticks, not clocks.
    assign w_start_done = tick_i && (r_timer == TW'(START_TICKS - 1));
    assign w_show_done  = tick_i && (r_timer == TW'(SHOW_TICKS - 1));
    assign w_leds_shl   = {r_leds[NUM_LEDS-2:0], 1'b1};
    assign w_leds_shr   = {1'b0, r_leds[NUM_LEDS-1:1]};
    assign w_misses_inc = r_misses + 4'd1;
    assign w_lfsr_next  = {1'b0, r_lfsr[COUNT_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);

    assign count_o  = r_count;
    assign target_o = r_target;
    assign misses_o = r_misses;
    assign state_o  = r_state;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode plus display enables, flags and the WON blink.
    always_comb begin
        w_next      = r_state;
        count_en_o  = 1'b1;
        target_en_o = 1'b0;
        won_o       = 1'b0;
        lost_o      = 1'b0;
        leds_o      = r_leds;
        case (r_state)
            S_IDLE: begin
                if (go_i) w_next = S_STARTING;
            end
            S_STARTING: begin
                if (w_start_done) w_next = S_COUNTING;
            end
            S_COUNTING: begin
                target_en_o = 1'b1;
                if (stop_i) w_next = (r_count == r_target) ? S_CORRECT : S_WRONG;
            end
            S_CORRECT: begin
                count_en_o  = ~r_timer[0];
                target_en_o = ~r_timer[0];
                if (w_show_done) w_next = (&w_leds_shl) ? S_WON : S_IDLE;
            end
            S_WRONG: begin
                count_en_o  = ~r_timer[0];
                target_en_o = r_timer[0];
                if (w_show_done)
                    w_next = (w_misses_inc == 4'(MAX_MISSES)) ? S_LOST : S_IDLE;
            end
            S_WON: begin
                target_en_o = 1'b1;
                won_o       = 1'b1;
                leds_o      = r_timer[0] ? '0 : '1;
                if (go_i) w_next = S_IDLE;
            end
            S_LOST: begin
                target_en_o = 1'b1;
                lost_o      = 1'b1;
                leds_o      = '0;
                if (go_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: timer, LFSR, counter, target, LEDs and miss tally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer  <= '0;
            r_lfsr   <= LFSR_SEED;
            r_count  <= '0;
            r_target <= '0;
            r_leds   <= '0;
            r_misses <= '0;
            r_mode   <= 1'b0;
        end else begin
            if (w_next != r_state) r_timer <= '0;
            else if (tick_i)       r_timer <= r_timer + TW'(1);
            case (r_state)
                S_IDLE: begin
                    r_lfsr <= w_lfsr_next;
                    if (load_i) begin
                        r_leds   <= switches_i;
                        r_misses <= '0;
                    end
                    if (go_i) begin
                        r_target <= r_lfsr;
                        r_mode   <= mode_i;
                        r_count  <= mode_i ? '0 : '1;
                    end
                end
                S_COUNTING: begin
                    // A stop freezes the compared value even on a tick cycle.
                    if (!stop_i && tick_i)
                        r_count <= r_mode ? r_count + COUNT_W'(1) : r_count - COUNT_W'(1);
                end
                S_CORRECT: begin
                    if (w_show_done) r_leds <= w_leds_shl;
                end
                S_WRONG: begin
                    if (w_show_done) begin
                        r_misses <= w_misses_inc;
                        r_leds   <= w_leds_shr;
                    end
                end
                S_WON, S_LOST: begin
                    if (go_i) begin
                        r_leds   <= '0;
                        r_misses <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
